// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the two cache clients and the unified word memory.
interface mem_arbiter_if #(
  parameter int unsigned AddrW = 10
);
  // icache side
  logic             i_read;
  logic [5:0]       i_address;
  logic [127:0]     i_readdata;
  logic             i_busywait;
  // dcache side
  logic             d_read;
  logic             d_write;
  logic [5:0]       d_address;
  logic [31:0]      d_writedata;
  logic [31:0]      d_readdata;
  logic             d_busywait;
  // unified memory side
  logic             mem_read;
  logic             mem_write;
  logic [AddrW-1:0] mem_address;
  logic [31:0]      mem_writedata;
  logic [31:0]      mem_readdata;
  logic             mem_busywait;

  // The arbiter: responder to both caches, requester towards memory.
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
    input  mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata
  );

  // The surrounding system: caches plus memory.
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
    output mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one 32-bit word port of a unified memory between icache (4-beat 128b blocks)
// and dcache (single-beat 32b blocks). dcache has priority; a write beats a read.
module mem_arbiter #(
  parameter int unsigned AddrW    = 10,
  parameter int unsigned DataBase = 256
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StDRd, StDWr, StIRd, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   beat_q;
  logic         gap_q;
  logic [5:0]   i_addr_q;
  logic [5:0]   d_addr_q;
  logic [127:0] i_readdata_q;
  logic [31:0]  d_readdata_q;

  logic d_active;
  logic d_done;
  logic i_beat_done;
  logic i_done;

  assign d_active    = (state_q == StDRd) || (state_q == StDWr);
  assign d_done      = d_active && !bus.mem_busywait;
  // gap_q marks the idle cycle between instruction beats; no word completes then
  assign i_beat_done = (state_q == StIRd) && !gap_q && !bus.mem_busywait;
  assign i_done      = i_beat_done && (beat_q == 2'd3);

  assign bus.i_readdata = i_readdata_q;
  assign bus.d_readdata = d_readdata_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant priority in idle, completion on memory ready
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.d_write) begin
          state_d = StDWr;
        end else if (bus.d_read) begin
          state_d = StDRd;
        end else if (bus.i_read) begin
          state_d = StIRd;
        end
      end
      StDRd, StDWr: begin
        if (d_done) state_d = StDone;
      end
      StIRd: begin
        if (i_done) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: memory request decode and client stalls
  always_comb begin
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    unique case (state_q)
      StDRd: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = AddrW'(DataBase) + AddrW'(d_addr_q);
      end
      StDWr: begin
        bus.mem_write     = 1'b1;
        bus.mem_address   = AddrW'(DataBase) + AddrW'(d_addr_q);
        bus.mem_writedata = bus.d_writedata;
      end
      StIRd: begin
        bus.mem_read    = !gap_q;
        bus.mem_address = AddrW'({i_addr_q, beat_q});
      end
      default: ;
    endcase
    // Stalls follow the request combinationally; reset forces them low
    bus.i_busywait = rst_n && bus.i_read && !i_done;
    bus.d_busywait = rst_n && (bus.d_read || bus.d_write) && !d_done;
  end

  // Datapath: address capture on grant, beat sequencing, read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q       <= 2'd0;
      gap_q        <= 1'b0;
      i_addr_q     <= '0;
      d_addr_q     <= '0;
      i_readdata_q <= '0;
      d_readdata_q <= '0;
    end else begin
      // Sampling every idle cycle leaves the grant-edge value held for the transfer
      if (state_q == StIdle) begin
        i_addr_q <= bus.i_address;
        d_addr_q <= bus.d_address;
      end
      if ((state_q == StDRd) && !bus.mem_busywait) begin
        d_readdata_q <= bus.mem_readdata;
      end
      if (state_q == StIRd) begin
        if (gap_q) begin
          gap_q <= 1'b0;
        end else if (!bus.mem_busywait) begin
          i_readdata_q[{beat_q, 5'd0} +: 32] <= bus.mem_readdata;
          // 2-bit counter wraps to 0 after the last beat
          beat_q <= beat_q + 2'd1;
          gap_q  <= (beat_q != 2'd3);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_mem_arbiter;
  localparam int unsigned AddrW = 10;
  localparam logic [1:0] KMemRd = 2'd0;
  localparam logic [1:0] KMemWr = 2'd1;
  localparam logic [1:0] KDDone = 2'd2;
  localparam logic [1:0] KIDone = 2'd3;

  typedef struct packed {
    logic [1:0]   kind;
    logic [9:0]   addr;
    logic [127:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AddrW(AddrW)) bus ();

  mem_arbiter #(.AddrW(AddrW), .DataBase(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   vectors = 0;
  int   fails = 0;
  int   overlap_cnt = 0;
  int   rise_cnt = 0;
  logic prev_rd = 1'b0;
  bit   sb_en = 1'b1;
  bit   d_pend = 1'b0;
  bit   i_pend = 1'b0;
  ev_t  exp_q[$];

  // Memory model: busy for lat cycles per request, word written on completion edge
  bit [31:0] mem [1024];
  int        lat = 1;
  int        cnt = 0;
  bit        rand_lat = 1'b0;
  bit        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (cnt < lat);
  assign bus.mem_readdata = mem[bus.mem_address];

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if ((bus.mem_read || bus.mem_write) && !bus.mem_busywait) begin
      if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
      cnt <= 0;
      if (rand_lat) lat <= $urandom_range(0, 3);
    end else if (bus.mem_read || bus.mem_write) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [9:0] addr, input logic [127:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [1:0] kind, input logic [9:0] addr, input logic [127:0] data,
                        input string name);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event kind=%0d addr=%0d data=%h, none required",
               name, kind, addr, data);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind !== kind || e.addr !== addr || e.data !== data) begin
      fails++;
      $display("FAIL %s: got kind=%0d addr=%0d data=%h, required kind=%0d addr=%0d data=%h",
               name, kind, addr, data, e.kind, e.addr, e.data);
    end
  endtask

  // Monitor: memory word completions and client completions, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_read && bus.mem_write) overlap_cnt++;
      if (bus.mem_read && !prev_rd) rise_cnt++;
      prev_rd = bus.mem_read;
      if (sb_en) begin
        if (d_pend) begin
          sb_pop(KDDone, '0, {96'b0, bus.d_readdata}, "d_done");
          d_pend = 1'b0;
        end
        if (i_pend) begin
          sb_pop(KIDone, '0, bus.i_readdata, "i_done");
          i_pend = 1'b0;
        end
        if ((bus.mem_read || bus.mem_write) && !bus.mem_busywait) begin
          if (bus.mem_write) sb_pop(KMemWr, bus.mem_address, {96'b0, bus.mem_writedata}, "mem_wr");
          else sb_pop(KMemRd, bus.mem_address, '0, "mem_rd");
          if (bus.mem_address >= 10'd256) chk("d_busy_low_on_done", {127'b0, bus.d_busywait}, '0);
        end
        if ((bus.d_read || bus.d_write) && !bus.d_busywait) d_pend = 1'b1;
        if (bus.i_read && !bus.i_busywait) i_pend = 1'b1;
      end
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic d_req(input bit wr, input bit rd, input logic [5:0] a, input logic [31:0] wd,
                       input bit hold);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    bus.d_write = wr;
    bus.d_read = rd;
    bus.d_address = a;
    bus.d_writedata = wd;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!bus.d_busywait) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      fails++;
      $display("FAIL d_timeout: d_busywait still 1 after 200 cycles, required 0");
    end
    @(posedge clk);
    #1;
    if (hold) begin
      @(negedge clk);
      chk("done_no_access", {126'b0, bus.mem_read, bus.mem_write}, '0);
      @(posedge clk);
      #1;
    end
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
  endtask

  task automatic i_req(input logic [5:0] a);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    bus.i_read = 1'b1;
    bus.i_address = a;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (!bus.i_busywait) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      fails++;
      $display("FAIL i_timeout: i_busywait still 1 after 400 cycles, required 0");
    end
    @(posedge clk);
    #1 bus.i_read = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_rw"}, {126'b0, bus.mem_read, bus.mem_write}, '0);
    chk({tag, "_mem_addr"}, {118'b0, bus.mem_address}, '0);
    chk({tag, "_mem_wdata"}, {96'b0, bus.mem_writedata}, '0);
    chk({tag, "_busy"}, {126'b0, bus.i_busywait, bus.d_busywait}, '0);
    chk({tag, "_i_rdata"}, bus.i_readdata, '0);
    chk({tag, "_d_rdata"}, {96'b0, bus.d_readdata}, '0);
  endtask

  initial begin
    int rises;
    bit seen;
    bit ib;
    bit done;
    logic [31:0] shadow [64];
    logic [31:0] last_rd;
    time t_end;

    bus.i_read = 1'b0;
    bus.i_address = '0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_address = '0;
    bus.d_writedata = '0;

    // Reset state, during and after reset
    #2 check_idle_outputs("in_reset");
    #10 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    poke(10'd261, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) poke(10'(8 + k), 32'(k + 1));
    for (int k = 0; k < 4; k++) poke(10'(k), 32'(10 + k));
    for (int k = 0; k < 4; k++) poke(10'(12 + k), 32'(21 + k));
    for (int k = 0; k < 4; k++) poke(10'(4 + k), 32'hC0DE_0000 + 32'(k));

    // Data read, address 5 -> word 261
    push(KMemRd, 10'd261, '0);
    push(KDDone, '0, {96'b0, 32'hDEADBEEF});
    d_req(1'b0, 1'b1, 6'd5, '0, 1'b0);
    repeat (3) @(posedge clk);

    // Instruction read, address 2 -> words 8..11 as four separate pulses
    rises = rise_cnt;
    for (int k = 0; k < 4; k++) push(KMemRd, 10'(8 + k), '0);
    push(KIDone, '0, {32'd4, 32'd3, 32'd2, 32'd1});
    i_req(6'd2);
    repeat (3) @(posedge clk);
    chk("i_four_pulses", 128'(rise_cnt - rises), 128'd4);

    // Simultaneous I read and D write: write first, I stalled throughout
    push(KMemWr, 10'd256, {96'b0, 32'hA5A5A5A5});
    push(KDDone, '0, {96'b0, 32'hDEADBEEF});
    for (int k = 0; k < 4; k++) push(KMemRd, 10'(k), '0);
    push(KIDone, '0, {32'd13, 32'd12, 32'd11, 32'd10});
    fork
      d_req(1'b1, 1'b0, 6'd0, 32'hA5A5A5A5, 1'b0);
      i_req(6'd0);
      begin
        seen = 1'b0;
        ib = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
          @(negedge clk);
          if (bus.mem_write) begin
            seen = 1'b1;
            ib = bus.i_busywait;
          end
        end
        chk("i_busy_during_d_write", {126'b0, seen, ib}, 128'd3);
      end
    join
    repeat (3) @(posedge clk);
    chk("mem256_written", {96'b0, mem[256]}, {96'b0, 32'hA5A5A5A5});

    // Write and read both high: write only
    push(KMemWr, 10'd263, {96'b0, 32'h00000077});
    push(KDDone, '0, {96'b0, 32'hDEADBEEF});
    d_req(1'b1, 1'b1, 6'd7, 32'h00000077, 1'b0);
    repeat (3) @(posedge clk);

    // Request held through the turnaround cycle: no duplicate access
    poke(10'd261, 32'h12345678);
    push(KMemRd, 10'd261, '0);
    push(KDDone, '0, {96'b0, 32'h12345678});
    d_req(1'b0, 1'b1, 6'd5, '0, 1'b1);
    repeat (4) @(posedge clk);
    chk("sb_drained_directed", 128'(exp_q.size()), '0);

    // Reset mid-fetch at beat 2, then the held request refetches from beat 0
    sb_en = 1'b0;
    lat = 2;
    @(posedge clk);
    #1;
    bus.i_read = 1'b1;
    bus.i_address = 6'd3;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_read && bus.mem_address == 10'd14) seen = 1'b1;
    end
    chk("reached_beat2", {127'b0, seen}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_read_drop", {127'b0, bus.mem_read}, '0);
    chk("rst_i_busy_low", {127'b0, bus.i_busywait}, '0);
    chk("rst_i_rdata_clear", bus.i_readdata, '0);
    chk("rst_d_rdata_clear", {96'b0, bus.d_readdata}, '0);
    for (int k = 0; k < 4; k++) push(KMemRd, 10'(12 + k), '0);
    push(KIDone, '0, {32'd24, 32'd23, 32'd22, 32'd21});
    sb_en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!bus.i_busywait) done = 1'b1;
    end
    chk("refetch_done", {127'b0, done}, 128'd1);
    @(posedge clk);
    #1 bus.i_read = 1'b0;
    repeat (3) @(posedge clk);
    chk("sb_drained_reset", 128'(exp_q.size()), '0);

    // Mixed random traffic with random memory latency; clients check their own data
    sb_en = 1'b0;
    rand_lat = 1'b1;
    lat = 1;
    for (int k = 0; k < 64; k++) shadow[k] = mem[256 + k];
    last_rd = 32'h0;
    t_end = $time + 20000;
    fork
      begin
        while ($time < t_end) begin
          int op;
          logic [5:0] a;
          logic [31:0] wd;
          op = $urandom_range(0, 2);
          a = 6'($urandom_range(0, 63));
          wd = $urandom;
          if (op == 0) begin
            d_req(1'b0, 1'b1, a, '0, 1'b0);
            last_rd = shadow[a];
            chk("rand_d_read", {96'b0, bus.d_readdata}, {96'b0, last_rd});
          end else begin
            d_req(1'b1, op == 2, a, wd, 1'b0);
            shadow[a] = wd;
            chk("rand_d_rdata_held", {96'b0, bus.d_readdata}, {96'b0, last_rd});
          end
          repeat ($urandom_range(1, 3)) @(posedge clk);
        end
      end
      begin
        while ($time < t_end) begin
          int a;
          a = $urandom_range(0, 3);
          i_req(6'(a));
          chk("rand_i_read", bus.i_readdata,
              {mem[4 * a + 3], mem[4 * a + 2], mem[4 * a + 1], mem[4 * a]});
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join
    repeat (4) @(posedge clk);

    chk("no_rd_wr_overlap", 128'(overlap_cnt), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
